// File: rtl/key_led_feedback.sv
`default_nettype none
// ============================================================================
//  Module   : key_led_feedback
//  Purpose  : Turns one-cycle key-event pulses into visible LED blink
//             sequences (BLINKS on/off periods per event). Events arriving
//             while a sequence plays are held in a saturating pending count
//             and replayed back to back. An event that finds the pending
//             count full is dropped and flagged for one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module key_led_feedback #(
  parameter int ON_TIME  = 1920000,  // LED-on cycles per blink
  parameter int OFF_TIME = 1920000,  // LED-off cycles after each blink
  parameter int BLINKS   = 2,        // blinks per event
  parameter int PEND_MAX = 3,        // max queued events
  parameter int BITS     = 21,       // timer width
  parameter int PBITS    = 2         // pending / blink-index width
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             event_i,
  output logic             led_o,
  output logic             busy_o,
  output logic [PBITS-1:0] pend_o,
  output logic             overflow_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ON   = 2'd1;
  localparam logic [1:0] c_OFF  = 2'd2;

  localparam logic [BITS-1:0]  c_ON_LAST    = BITS'(ON_TIME - 1);
  localparam logic [BITS-1:0]  c_OFF_LAST   = BITS'(OFF_TIME - 1);
  localparam logic [PBITS-1:0] c_BLINK_LAST = PBITS'(BLINKS - 1);
  localparam logic [PBITS-1:0] c_PEND_MAX   = PBITS'(PEND_MAX);

  logic [1:0]       r_state;
  logic [BITS-1:0]  r_timer;
  logic [PBITS-1:0] r_blink_idx;
  logic [PBITS-1:0] r_pend;
  logic             r_led;
  logic             r_busy;
  logic             r_ovf;

  logic [1:0]       w_state_nxt;
  logic [BITS-1:0]  w_timer_nxt;
  logic [PBITS-1:0] w_blink_nxt;
  logic [PBITS-1:0] w_pend_nxt;
  logic             w_ovf_nxt;
  logic             w_pend_dec;   // a queued event starts now
  logic             w_direct;     // this cycle's event starts now, bypassing the queue
  logic             w_queue;      // this cycle's event must go to the queue

  // Sequencer: timer, blink index and state transitions
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_blink_nxt = r_blink_idx;
    w_pend_dec  = 1'b0;
    w_direct    = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (event_i) begin
          w_state_nxt = c_ON;
          w_timer_nxt = '0;
          w_blink_nxt = '0;
        end
      end
      c_ON: begin
        if (r_timer == c_ON_LAST) begin
          w_state_nxt = c_OFF;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + BITS'(1);
        end
      end
      c_OFF: begin
        if (r_timer == c_OFF_LAST) begin
          w_timer_nxt = '0;
          if (r_blink_idx != c_BLINK_LAST) begin
            w_state_nxt = c_ON;
            w_blink_nxt = r_blink_idx + PBITS'(1);
          end else if (r_pend != '0) begin
            // Next queued event follows with no gap
            w_state_nxt = c_ON;
            w_blink_nxt = '0;
            w_pend_dec  = 1'b1;
          end else if (event_i) begin
            // Event on the very last OFF cycle starts the next sequence itself
            w_state_nxt = c_ON;
            w_blink_nxt = '0;
            w_direct    = 1'b1;
          end else begin
            w_state_nxt = c_IDLE;
            w_blink_nxt = '0;
          end
        end else begin
          w_timer_nxt = r_timer + BITS'(1);
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_timer_nxt = '0;
        w_blink_nxt = '0;
      end
    endcase
  end

  // Pending queue: enqueue, dequeue, saturation and overflow flag
  always_comb begin
    w_queue    = event_i && (r_state != c_IDLE) && !w_direct;
    w_pend_nxt = r_pend;
    w_ovf_nxt  = 1'b0;
    if (w_queue) begin
      if (w_pend_dec) begin
        // Dequeue and enqueue in the same cycle cancel out; never an overflow
        w_pend_nxt = r_pend;
      end else if (r_pend < c_PEND_MAX) begin
        w_pend_nxt = r_pend + PBITS'(1);
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else if (w_pend_dec) begin
      w_pend_nxt = r_pend - PBITS'(1);
    end
  end

  // State registers; outputs are decoded from the next state so they stay registered
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= c_IDLE;
      r_timer     <= '0;
      r_blink_idx <= '0;
      r_pend      <= '0;
      r_led       <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_blink_idx <= w_blink_nxt;
      r_pend      <= w_pend_nxt;
      r_led       <= (w_state_nxt == c_ON);
      r_busy      <= (w_state_nxt != c_IDLE);
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign led_o      = r_led;
  assign busy_o     = r_busy;
  assign pend_o     = r_pend;
  assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_key_led_feedback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_led_feedback
//  Purpose  : Self-checking bench for key_led_feedback. Two instances
//             (BLINKS=2 and BLINKS=1) share one stimulus stream; a
//             sequence-position reference model predicts each cycle's outputs
//             into per-instance queues, and a monitor compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_led_feedback;

  localparam int ON_T = 4;
  localparam int OFF_T = 3;
  localparam int PMAX = 2;
  localparam int BW = 3;
  localparam int PW = 2;

  typedef struct packed {
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          event_i = 1'b0;
  logic          led_a, busy_a, ovf_a;
  logic [PW-1:0] pend_a;
  logic          led_b, busy_b, ovf_b;
  logic [PW-1:0] pend_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: active flag, position inside the sequence, queue depth
  bit m_act[2];
  int m_pos[2];
  int m_pend[2];

  always #5 sys_clk = ~sys_clk;

  key_led_feedback #(
    .ON_TIME(ON_T), .OFF_TIME(OFF_T), .BLINKS(2), .PEND_MAX(PMAX), .BITS(BW), .PBITS(PW)
  ) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .event_i(event_i),
    .led_o(led_a), .busy_o(busy_a), .pend_o(pend_a), .overflow_o(ovf_a)
  );

  key_led_feedback #(
    .ON_TIME(ON_T), .OFF_TIME(OFF_T), .BLINKS(1), .PEND_MAX(PMAX), .BITS(BW), .PBITS(PW)
  ) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .event_i(event_i),
    .led_o(led_b), .busy_o(busy_b), .pend_o(pend_b), .overflow_o(ovf_b)
  );

  // One clock edge of the behavioural model; returns outputs expected after the edge
  task automatic model_step(input int i, input int blinks, input bit e, output exp_t x);
    int len;
    bit ovf;
    len = blinks * (ON_T + OFF_T);
    ovf = 1'b0;
    if (!m_act[i]) begin
      if (e) begin
        m_act[i] = 1'b1;
        m_pos[i] = 0;
      end
    end else if (m_pos[i] == len - 1) begin
      if (m_pend[i] > 0) begin
        m_pos[i]  = 0;
        m_pend[i] = m_pend[i] - 1;
        if (e) m_pend[i] = m_pend[i] + 1;
      end else if (e) begin
        m_pos[i] = 0;
      end else begin
        m_act[i] = 1'b0;
      end
    end else begin
      m_pos[i] = m_pos[i] + 1;
      if (e) begin
        if (m_pend[i] < PMAX) m_pend[i] = m_pend[i] + 1;
        else ovf = 1'b1;
      end
    end
    x.led  = m_act[i] && ((m_pos[i] % (ON_T + OFF_T)) < ON_T);
    x.busy = m_act[i];
    x.pend = PW'(m_pend[i]);
    x.ovf  = ovf;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i]  = 1'b0;
      m_pos[i]  = 0;
      m_pend[i] = 0;
    end
  endtask

  task automatic cmp(input string nm, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got led=%b busy=%b pend=%0d ovf=%b, expected led=%b busy=%b pend=%0d ovf=%b",
               nm, $time, got.led, got.busy, got.pend, got.ovf,
               exp.led, exp.busy, exp.pend, exp.ovf);
    end
  endtask

  // One cycle of stimulus: drive event, predict both instances
  task automatic drive(input bit e);
    exp_t xa, xb;
    @(negedge sys_clk);
    event_i = e;
    model_step(0, 2, e, xa);
    q_a.push_back(xa);
    model_step(1, 1, e, xb);
    q_b.push_back(xb);
  endtask

  // Play a pattern: bit c of pat is the event for offset c
  task automatic play(input logic [63:0] pat, input int len);
    for (int c = 0; c < len; c++) drive(pat[c]);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    exp_t zero;
    zero = '0;
    @(negedge sys_clk);
    event_i = 1'b0;
    sys_rst = 1'b1;
    #1;
    cmp("async_reset_a", {led_a, busy_a, pend_a, ovf_a}, zero);
    cmp("async_reset_b", {led_b, busy_b, pend_b, ovf_b}, zero);
    model_reset();
    q_a.push_back(zero);
    q_b.push_back(zero);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Monitor: every cycle the DUTs present registered outputs, compare against the queue head
  initial begin
    exp_t x;
    forever begin
      @(posedge sys_clk);
      #1;
      if (q_a.size() > 0) begin
        x = q_a.pop_front();
        cmp("dut_a_outputs", {led_a, busy_a, pend_a, ovf_a}, x);
      end
      if (q_b.size() > 0) begin
        x = q_b.pop_front();
        cmp("dut_b_outputs", {led_b, busy_b, pend_b, ovf_b}, x);
      end
    end
  end

  initial begin
    exp_t zero;
    int   density;
    zero = '0;
    model_reset();
    #2;
    cmp("reset_state_a", {led_a, busy_a, pend_a, ovf_a}, zero);
    cmp("reset_state_b", {led_b, busy_b, pend_b, ovf_b}, zero);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    play(64'h1, 30);       // single event
    play(64'h41, 40);      // second event queued mid-sequence
    play(64'h1D, 60);      // queue fills, one overflow
    play(64'h4001, 40);    // event on last OFF cycle is consumed directly
    play(64'h7, 40);       // three back-to-back events
    play(64'h5, 9);        // reset in the middle of a sequence with one pending
    do_reset();
    play(64'h1, 30);

    for (int blk = 0; blk < 10; blk++) begin
      density = int'($urandom_range(5, 60));
      for (int c = 0; c < 150; c++) drive($urandom_range(0, 99) < density);
      if ($urandom_range(0, 3) == 0) do_reset();
    end
    play(64'h0, 40);

    @(posedge sys_clk);
    #3;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_led_feedback.md
Name: key_led_feedback

Overview:
- Output-side counterpart of the key debounce/detect input path.
- Accepts one-cycle key-event pulses and turns each into a human-visible LED blink sequence of BLINKS on/off periods.
- Events that arrive while a sequence is playing are queued in a saturating pending counter and played back in order.
- Overflow beyond PEND_MAX is flagged. Sits between the key detect block and a board LED pin.

Parameters:
ON_TIME, 1920000, LED-on cycles per blink (>=1)
OFF_TIME, 1920000, LED-off cycles after each blink, including the last (>=1)
BLINKS, 2, blinks per event (>=1)
PEND_MAX, 3, max queued events (>=1)
BITS, 21, timer width; must hold max(ON_TIME,OFF_TIME)-1
PBITS, 2, pending/blink-index width; must hold max(PEND_MAX, BLINKS-1)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
event_i  in  1  one-cycle key-event pulse (each high cycle = one event)
led_o  out  1  LED drive, registered, high = lit
busy_o  out  1  high while a sequence is playing (state != IDLE)
pend_o  out  PBITS  queued events not yet started
overflow_o  out  1  one-cycle pulse: event dropped, queue full

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous, active-high, on sys_rst.
  - Reset forces state=IDLE, timer=0, blink_idx=0, pend=0, led_o=0, overflow_o=0, busy_o=0.
  - Reset mid-sequence aborts it immediately and discards the queue.
- States: IDLE, ON, OFF. led_o=1 exactly in ON. busy_o=1 in ON and OFF. All outputs are registered.
- IDLE: event_i=1 at an edge -> ON next cycle, timer=0, blink_idx=0. Latency is 1 cycle, event edge to led_o high.
- ON: timer increments each cycle. At timer==ON_TIME-1 -> OFF, timer=0. led_o is high for exactly ON_TIME cycles.
- OFF: timer increments each cycle. At timer==OFF_TIME-1:
  - blink_idx<BLINKS-1 -> ON, blink_idx+1, timer=0.
  - last blink and pend>0 -> ON, blink_idx=0, pend-1.
  - last blink, pend==0, event_i=1 this cycle -> ON, blink_idx=0, pend unchanged. The event is consumed directly.
  - last blink, pend==0, no event -> IDLE.
- One sequence lasts BLINKS*(ON_TIME+OFF_TIME) cycles. Back-to-back sequences have no extra gap.
- Queueing: event_i=1 in ON or OFF, and not consumed directly as above:
  - pend<PEND_MAX -> pend+1.
  - otherwise -> pend unchanged, overflow_o=1 for the next cycle only.
- Simultaneous queue and consume: an event in the same cycle a pending event is consumed leaves pend unchanged (-1 +1). overflow_o is not asserted, even when pend==PEND_MAX.
- Timer arithmetic: unsigned, BITS wide. It never wraps, because it is cleared on every transition.
- pend_o never exceeds PEND_MAX and never underflows.
- event_i held high N cycles counts as N events. Upstream delivers single-cycle pulses.

Test Plan:
All scenarios use ON_TIME=4, OFF_TIME=3, BLINKS=2, PEND_MAX=2.
1. Reset, then event_i pulse at cycle 10:
   - led_o high cycles 11-14 and 18-21, low 15-17 and 22-24.
   - busy_o high 11-24, low from 25. pend_o=0 throughout.
2. Pulses at 10 and 16:
   - pend_o=1 from 17.
   - At 25 the second sequence starts (led_o high 25-28), pend_o=0 from 25. busy_o stays high continuously until 38.
3. Pulses at 10, 12, 13, 14:
   - pend_o reaches 2 after 13.
   - overflow_o high at cycle 15 only.
   - Exactly three sequences play, ending with busy_o low at cycle 53.
4. Pulse at 10, second pulse exactly at 24 (last OFF cycle, pend=0):
   - led_o high at 25 with no IDLE cycle. pend_o stays 0. overflow_o stays 0.
5. Pulses at 10 and 12; pend=1; sys_rst asserted asynchronously mid-cycle 19:
   - led_o, busy_o, pend_o drop to 0 immediately, before the next edge.
   - After release, a new pulse plays a fresh sequence from blink 0.
6. Back-to-back with BLINKS=1, pulses at 10, 11, 12:
   - led_o pattern 4 on / 3 off repeated three times (11-14, 18-21, 25-28).
   - pend_o goes 1, 2, 1, 0. No overflow.
